register_file: RTL

//   Architectural state sink for the stage_wb write interfaces: 32 general-purpose

---
 rtl/register_file.sv | 96 +++++++++
 1 files changed

// File: rtl/register_file.sv
// 32-entry GPR file with HI/LO: one write port, two combinational read ports.
// Optional write-through bypass is enabled by defining REGISTER_FILE_BYPASS_EN.
module register_file #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     write_enable,
   input  logic [ADDRESS_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0]    write_data,
   input  logic                     read_enable_a,
   input  logic [ADDRESS_WIDTH-1:0] read_address_a,
   output logic [DATA_WIDTH-1:0]    read_data_a,
   input  logic                     read_enable_b,
   input  logic [ADDRESS_WIDTH-1:0] read_address_b,
   output logic [DATA_WIDTH-1:0]    read_data_b,
   input  logic                     hi_write_enable,
   input  logic [DATA_WIDTH-1:0]    hi_write_data,
   input  logic                     lo_write_enable,
   input  logic [DATA_WIDTH-1:0]    lo_write_data,
   output logic [DATA_WIDTH-1:0]    hi_read_data,
   output logic [DATA_WIDTH-1:0]    lo_read_data
);

   localparam int REGISTER_COUNT = 2 ** ADDRESS_WIDTH;

   logic [DATA_WIDTH-1:0] registers [REGISTER_COUNT];
   logic [DATA_WIDTH-1:0] hi_register;
   logic [DATA_WIDTH-1:0] lo_register;

   logic gpr_write_valid;
   assign gpr_write_valid = write_enable && (write_address != '0);

   // NOTE: the whole array is cleared on reset because pre-reset contents must never
   // be readable afterwards; non-blocking assignments keep every register updating
   // from pre-edge values, and reset simply takes priority over all writes.
   always_ff @(posedge clock) begin
      if (reset) begin
         registers   <= '{default: '0};
         hi_register <= '0;
         lo_register <= '0;
      end else begin
         if (gpr_write_valid) begin
            registers[write_address] <= write_data;
         end
         if (hi_write_enable) begin
            hi_register <= hi_write_data;
         end
         if (lo_write_enable) begin
            lo_register <= lo_write_data;
         end
      end
   end

   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      read_data_a = '0;
      if (!reset && read_enable_a && (read_address_a != '0)) begin
         read_data_a = registers[read_address_a];
`ifdef REGISTER_FILE_BYPASS_EN
         if (gpr_write_valid && (write_address == read_address_a)) begin
            read_data_a = write_data;
         end
`endif
      end
   end

   always_comb begin
      read_data_b = '0;
      if (!reset && read_enable_b && (read_address_b != '0)) begin
         read_data_b = registers[read_address_b];
`ifdef REGISTER_FILE_BYPASS_EN
         if (gpr_write_valid && (write_address == read_address_b)) begin
            read_data_b = write_data;
         end
`endif
      end
   end

   // HI/LO feed stage_ex, which layers its own mem/wb forwarding on top of these.
   always_comb begin
      hi_read_data = '0;
      lo_read_data = '0;
      if (!reset) begin
`ifdef REGISTER_FILE_BYPASS_EN
         hi_read_data = hi_write_enable ? hi_write_data : hi_register;
         lo_read_data = lo_write_enable ? lo_write_data : lo_register;
`else
         hi_read_data = hi_register;
         lo_read_data = lo_register;
`endif
      end
   end

endmodule
